// File: rtl/spi_ram_port_arbiter_pkg.sv
// Shared types and defaults for the SPI/host RAM port arbiter.
package spi_ram_port_arbiter_pkg;

  localparam int unsigned MEM_WIDTH = 8;
  localparam int unsigned MEM_DEPTH = 256;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } spi_cmd_e;

  typedef enum logic {
    OWN_SPI  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  localparam logic [1:0] ARB_IDLE    = 2'd0;
  localparam logic [1:0] ARB_ACCESS  = 2'd1;
  localparam logic [1:0] ARB_RD_DATA = 2'd2;

  // On contention the requester that was not served last wins.
  function automatic owner_e rr_pick(input logic spi_pend, input logic host_pend,
                                     input owner_e last);
    if (spi_pend && host_pend) begin
      return (last == OWN_SPI) ? OWN_HOST : OWN_SPI;
    end
    return host_pend ? OWN_HOST : OWN_SPI;
  endfunction

endpackage

// File: rtl/spi_cmd_decoder.sv
// SPI command decode: address registers, one-entry pending RAM op buffer and sticky overflow.
module spi_cmd_decoder
  import spi_ram_port_arbiter_pkg::*;
#(
  parameter int unsigned MEM_WIDTH = spi_ram_port_arbiter_pkg::MEM_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_valid,
  input  logic [MEM_WIDTH+1:0] din,
  input  logic                 consume,
  output logic                 pend_valid,
  output logic                 pend_we,
  output logic [MEM_WIDTH-1:0] pend_addr,
  output logic [MEM_WIDTH-1:0] pend_wdata,
  output logic                 spi_ovf
);

  logic [MEM_WIDTH-1:0] wr_addr_q;
  logic [MEM_WIDTH-1:0] rd_addr_q;
  logic                 pend_valid_q;
  logic                 pend_we_q;
  logic [MEM_WIDTH-1:0] pend_addr_q;
  logic [MEM_WIDTH-1:0] pend_wdata_q;
  logic                 spi_ovf_q;

  spi_cmd_e             cmd;
  logic [MEM_WIDTH-1:0] payload;
  logic                 queue_op;
  logic                 slot_free;

  assign cmd       = spi_cmd_e'(din[MEM_WIDTH+1:MEM_WIDTH]);
  assign payload   = din[MEM_WIDTH-1:0];
  assign queue_op  = rx_valid && ((cmd == CMD_WR_DATA) || (cmd == CMD_RD_DATA));
  // A slot being drained this cycle can take the new op immediately.
  assign slot_free = !pend_valid_q || consume;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      spi_ovf_q    <= 1'b0;
    end else begin
      if (rx_valid && (cmd == CMD_WR_ADDR)) begin
        wr_addr_q <= payload;
      end
      if (rx_valid && (cmd == CMD_RD_ADDR)) begin
        rd_addr_q <= payload;
      end
      if (consume) begin
        pend_valid_q <= 1'b0;
      end
      if (queue_op) begin
        if (slot_free) begin
          pend_valid_q <= 1'b1;
          pend_we_q    <= (cmd == CMD_WR_DATA);
          if (cmd == CMD_WR_DATA) begin
            pend_addr_q  <= wr_addr_q;
            pend_wdata_q <= payload;
          end else begin
            pend_addr_q  <= rd_addr_q;
          end
        end else begin
          spi_ovf_q <= 1'b1;
        end
      end
    end
  end

  assign pend_valid = pend_valid_q;
  assign pend_we    = pend_we_q;
  assign pend_addr  = pend_addr_q;
  assign pend_wdata = pend_wdata_q;
  assign spi_ovf    = spi_ovf_q;

endmodule

// File: rtl/spi_ram_port_arbiter.sv
// Round-robin arbiter sharing a single-port RAM between the SPI command stream and a host port.
module spi_ram_port_arbiter
  import spi_ram_port_arbiter_pkg::*;
#(
  parameter int unsigned MEM_WIDTH = spi_ram_port_arbiter_pkg::MEM_WIDTH,
  parameter int unsigned MEM_DEPTH = spi_ram_port_arbiter_pkg::MEM_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_valid,
  input  logic [MEM_WIDTH+1:0] din,
  output logic [MEM_WIDTH-1:0] dout,
  output logic                 tx_valid,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [MEM_WIDTH-1:0] host_addr,
  input  logic [MEM_WIDTH-1:0] host_wdata,
  output logic                 host_gnt,
  output logic                 host_rvalid,
  output logic [MEM_WIDTH-1:0] host_rdata,
  output logic                 spi_ovf,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [MEM_WIDTH-1:0] ram_addr,
  output logic [MEM_WIDTH-1:0] ram_wdata,
  input  logic [MEM_WIDTH-1:0] ram_rdata
);

  if (MEM_DEPTH != (32'd1 << MEM_WIDTH)) begin : gen_depth_check
    $error("MEM_DEPTH must equal 2**MEM_WIDTH");
  end

  logic                 pend_valid;
  logic                 pend_we;
  logic [MEM_WIDTH-1:0] pend_addr;
  logic [MEM_WIDTH-1:0] pend_wdata;
  logic                 consume;

  logic [1:0]           state_q;
  owner_e               owner_q;
  owner_e               rr_q;
  owner_e               winner;

  logic                 ram_en_q;
  logic                 ram_we_q;
  logic [MEM_WIDTH-1:0] ram_addr_q;
  logic [MEM_WIDTH-1:0] ram_wdata_q;
  logic                 host_gnt_q;
  logic                 tx_valid_q;
  logic [MEM_WIDTH-1:0] dout_q;
  logic                 host_rvalid_q;
  logic [MEM_WIDTH-1:0] host_rdata_q;

  spi_cmd_decoder #(
    .MEM_WIDTH (MEM_WIDTH)
  ) u_spi_cmd_decoder (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .din        (din),
    .consume    (consume),
    .pend_valid (pend_valid),
    .pend_we    (pend_we),
    .pend_addr  (pend_addr),
    .pend_wdata (pend_wdata),
    .spi_ovf    (spi_ovf)
  );

  assign winner  = rr_pick(pend_valid, host_req, rr_q);
  assign consume = (state_q == ARB_ACCESS) && (owner_q == OWN_SPI);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      owner_q       <= OWN_SPI;
      rr_q          <= OWN_SPI;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      host_gnt_q    <= 1'b0;
      tx_valid_q    <= 1'b0;
      dout_q        <= '0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      tx_valid_q    <= 1'b0;
      host_rvalid_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (pend_valid || host_req) begin
            owner_q  <= winner;
            state_q  <= ARB_ACCESS;
            ram_en_q <= 1'b1;
            if (winner == OWN_HOST) begin
              ram_we_q    <= host_we;
              ram_addr_q  <= host_addr;
              ram_wdata_q <= host_wdata;
              host_gnt_q  <= 1'b1;
            end else begin
              ram_we_q    <= pend_we;
              ram_addr_q  <= pend_addr;
              ram_wdata_q <= pend_wdata;
            end
          end
        end
        ARB_ACCESS: begin
          ram_en_q   <= 1'b0;
          ram_we_q   <= 1'b0;
          host_gnt_q <= 1'b0;
          rr_q       <= owner_q;
          state_q    <= ram_we_q ? ARB_IDLE : ARB_RD_DATA;
        end
        ARB_RD_DATA: begin
          if (owner_q == OWN_SPI) begin
            tx_valid_q <= 1'b1;
            dout_q     <= ram_rdata;
          end else begin
            host_rvalid_q <= 1'b1;
            host_rdata_q  <= ram_rdata;
          end
          state_q <= ARB_IDLE;
        end
        default: begin
          state_q    <= ARB_IDLE;
          ram_en_q   <= 1'b0;
          ram_we_q   <= 1'b0;
          host_gnt_q <= 1'b0;
        end
      endcase
    end
  end

  assign ram_en      = ram_en_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign host_gnt    = host_gnt_q;
  assign tx_valid    = tx_valid_q;
  assign dout        = dout_q;
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;

  // The host may only withdraw its request in the cycle it sees host_gnt.
  host_req_held_a : assert property (@(posedge clk) disable iff (rst)
    $fell(host_req) |-> host_gnt);

endmodule

// File: tb/tb_spi_ram_port_arbiter.sv
// Directed bench for spi_ram_port_arbiter with a behavioural single-port RAM.
module tb_spi_ram_port_arbiter;
  import spi_ram_port_arbiter_pkg::*;

  logic       clk;
  logic       rst;
  logic       rx_valid;
  logic [9:0] din;
  logic [7:0] dout;
  logic       tx_valid;
  logic       host_req;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_gnt;
  logic       host_rvalid;
  logic [7:0] host_rdata;
  logic       spi_ovf;
  logic       ram_en;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;

  logic [7:0] mem [256];
  int         n_wr;
  int         n_checks;
  int         n_errors;

  spi_ram_port_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .din         (din),
    .dout        (dout),
    .tx_valid    (tx_valid),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .spi_ovf     (spi_ovf),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_wdata;
        n_wr          <= n_wr + 1;
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic spi_send(input logic [1:0] cmd, input logic [7:0] data);
    rx_valid = 1'b1;
    din      = {cmd, data};
    tick();
    rx_valid = 1'b0;
    din      = '0;
  endtask

  initial begin
    int         wr_base;
    logic       saw_rvalid;
    logic [7:0] seen_rdata;
    int         seen_wr;
    logic [7:0] seen_wdata;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    n_wr       = 0;
    n_checks   = 0;
    n_errors   = 0;
    ram_rdata  = 8'h00;
    rst        = 1'b1;
    rx_valid   = 1'b0;
    din        = '0;
    host_req   = 1'b0;
    host_we    = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    tick();
    tick();

    check_eq("rst_dout", 32'(dout), 32'h0);
    check_eq("rst_tx_valid", 32'(tx_valid), 32'h0);
    check_eq("rst_host_gnt", 32'(host_gnt), 32'h0);
    check_eq("rst_host_rvalid", 32'(host_rvalid), 32'h0);
    check_eq("rst_host_rdata", 32'(host_rdata), 32'h0);
    check_eq("rst_spi_ovf", 32'(spi_ovf), 32'h0);
    check_eq("rst_ram_en", 32'(ram_en), 32'h0);
    check_eq("rst_ram_we", 32'(ram_we), 32'h0);
    check_eq("rst_ram_addr", 32'(ram_addr), 32'h0);
    check_eq("rst_ram_wdata", 32'(ram_wdata), 32'h0);
    rst = 1'b0;
    tick();

    // SPI write 0x12 <- 0xAB, then SPI read it back
    spi_send(2'b00, 8'h12);
    spi_send(2'b01, 8'hAB);
    tick();
    check_eq("t1_wr_en", 32'(ram_en), 32'h1);
    check_eq("t1_wr_we", 32'(ram_we), 32'h1);
    check_eq("t1_wr_addr", 32'(ram_addr), 32'h12);
    check_eq("t1_wr_wdata", 32'(ram_wdata), 32'hAB);
    spi_send(2'b10, 8'h12);
    spi_send(2'b11, 8'h00);
    tick();
    check_eq("t1_rd_en", 32'(ram_en), 32'h1);
    check_eq("t1_rd_we", 32'(ram_we), 32'h0);
    check_eq("t1_rd_addr", 32'(ram_addr), 32'h12);
    tick();
    check_eq("t1_rd_data_tx_early", 32'(tx_valid), 32'h0);
    check_eq("t1_rd_data_en", 32'(ram_en), 32'h0);
    tick();
    check_eq("t1_tx_valid", 32'(tx_valid), 32'h1);
    check_eq("t1_dout", 32'(dout), 32'hAB);
    check_eq("t1_host_rvalid", 32'(host_rvalid), 32'h0);
    tick();
    check_eq("t1_tx_pulse", 32'(tx_valid), 32'h0);
    check_eq("t1_dout_hold", 32'(dout), 32'hAB);

    // Host read 0x12
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = 8'h12;
    tick();
    check_eq("t2_gnt", 32'(host_gnt), 32'h1);
    check_eq("t2_en", 32'(ram_en), 32'h1);
    check_eq("t2_we", 32'(ram_we), 32'h0);
    check_eq("t2_addr", 32'(ram_addr), 32'h12);
    host_req = 1'b0;
    tick();
    check_eq("t2_rvalid_early", 32'(host_rvalid), 32'h0);
    check_eq("t2_gnt_pulse", 32'(host_gnt), 32'h0);
    tick();
    check_eq("t2_rvalid", 32'(host_rvalid), 32'h1);
    check_eq("t2_rdata", 32'(host_rdata), 32'hAB);
    check_eq("t2_tx_valid", 32'(tx_valid), 32'h0);
    tick();
    check_eq("t2_rvalid_pulse", 32'(host_rvalid), 32'h0);

    // SPI write 0x30 <- 0x11 so SPI was served last
    spi_send(2'b00, 8'h30);
    spi_send(2'b01, 8'h11);
    tick();
    check_eq("t3_spi_addr", 32'(ram_addr), 32'h30);
    check_eq("t3_spi_wdata", 32'(ram_wdata), 32'h11);
    tick();
    // Contention: host wins, then SPI wins against a re-raised host request
    spi_send(2'b01, 8'h22);
    host_req   = 1'b1;
    host_we    = 1'b1;
    host_addr  = 8'h40;
    host_wdata = 8'h77;
    tick();
    check_eq("t3_host_first_gnt", 32'(host_gnt), 32'h1);
    check_eq("t3_host_first_addr", 32'(ram_addr), 32'h40);
    check_eq("t3_host_first_wdata", 32'(ram_wdata), 32'h77);
    check_eq("t3_host_first_we", 32'(ram_we), 32'h1);
    host_addr  = 8'h41;
    host_wdata = 8'h66;
    tick();
    check_eq("t3_idle_en", 32'(ram_en), 32'h0);
    tick();
    check_eq("t3_spi_next_en", 32'(ram_en), 32'h1);
    check_eq("t3_spi_next_addr", 32'(ram_addr), 32'h30);
    check_eq("t3_spi_next_wdata", 32'(ram_wdata), 32'h22);
    check_eq("t3_spi_next_gnt", 32'(host_gnt), 32'h0);
    tick();
    tick();
    check_eq("t3_host_again_gnt", 32'(host_gnt), 32'h1);
    check_eq("t3_host_again_addr", 32'(ram_addr), 32'h41);
    check_eq("t3_host_again_wdata", 32'(ram_wdata), 32'h66);
    host_req = 1'b0;
    check_eq("t4_ovf_before", 32'(spi_ovf), 32'h0);
    tick();

    // Host read holds the RAM while two SPI writes arrive back to back
    wr_base   = n_wr;
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = 8'h12;
    spi_send(2'b01, 8'h01);
    check_eq("t4_gnt", 32'(host_gnt), 32'h1);
    host_req = 1'b0;
    spi_send(2'b01, 8'h02);
    check_eq("t4_ovf", 32'(spi_ovf), 32'h1);
    saw_rvalid = 1'b0;
    seen_rdata = 8'h00;
    seen_wr    = 0;
    seen_wdata = 8'h00;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (host_rvalid) begin
        saw_rvalid = 1'b1;
        seen_rdata = host_rdata;
      end
      if (ram_en && ram_we) begin
        seen_wr++;
        seen_wdata = ram_wdata;
      end
    end
    check_eq("t4_host_rvalid_seen", 32'(saw_rvalid), 32'h1);
    check_eq("t4_host_rdata", 32'(seen_rdata), 32'hAB);
    check_eq("t4_write_strobes", 32'(seen_wr), 32'h1);
    check_eq("t4_write_data", 32'(seen_wdata), 32'h01);
    check_eq("t4_ram_writes", 32'(n_wr - wr_base), 32'h1);
    check_eq("t4_ovf_sticky", 32'(spi_ovf), 32'h1);

    // Reset during RD_DATA of an SPI read
    spi_send(2'b10, 8'h30);
    spi_send(2'b11, 8'h00);
    tick();
    check_eq("t5_rd_en", 32'(ram_en), 32'h1);
    check_eq("t5_rd_addr", 32'(ram_addr), 32'h30);
    tick();
    rst = 1'b1;
    tick();
    check_eq("t5_tx_valid", 32'(tx_valid), 32'h0);
    check_eq("t5_dout", 32'(dout), 32'h0);
    check_eq("t5_host_rdata", 32'(host_rdata), 32'h0);
    check_eq("t5_spi_ovf", 32'(spi_ovf), 32'h0);
    check_eq("t5_ram_en", 32'(ram_en), 32'h0);
    check_eq("t5_ram_addr", 32'(ram_addr), 32'h0);
    check_eq("t5_state", 32'(dut.state_q), 32'(ARB_IDLE));
    rst = 1'b0;
    tick();
    check_eq("t5_tx_after1", 32'(tx_valid), 32'h0);
    tick();
    check_eq("t5_tx_after2", 32'(tx_valid), 32'h0);
    check_eq("t5_en_after2", 32'(ram_en), 32'h0);

    // Top-of-range address
    spi_send(2'b00, 8'hFF);
    spi_send(2'b01, 8'h5A);
    tick();
    check_eq("t6_wr_addr", 32'(ram_addr), 32'hFF);
    check_eq("t6_wr_wdata", 32'(ram_wdata), 32'h5A);
    spi_send(2'b10, 8'hFF);
    spi_send(2'b11, 8'h00);
    tick();
    check_eq("t6_rd_addr", 32'(ram_addr), 32'hFF);
    check_eq("t6_rd_we", 32'(ram_we), 32'h0);
    tick();
    tick();
    check_eq("t6_tx_valid", 32'(tx_valid), 32'h1);
    check_eq("t6_dout", 32'(dout), 32'h5A);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
